// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;

    localparam int unsigned ADDR_W_DFLT = 5;
    localparam int unsigned DATA_W_DFLT = 32;

    // Register 0 is hardwired; writes to it are accepted and discarded.
    localparam int unsigned REG_ZERO = 0;

    // Which source won the most recent grant.
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } arb_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding loads, with two read lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_reg,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_reg,
    input  logic [ADDR_W-1:0] i_rd_reg1,
    input  logic [ADDR_W-1:0] i_rd_reg2,
    output logic              o_busy1_c,
    output logic              o_busy2_c,
    output logic [NREGS-1:0]  o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clear first, then set, so a newer load to the same register stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_reg] = 1'b0;
        end
        if (i_set_en && (i_set_reg != ADDR_W'(REG_ZERO))) begin
            w_busy_nxt[i_set_reg] = 1'b1;
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy1_c = r_busy[i_rd_reg1];
    assign o_busy2_c = r_busy[i_rd_reg2];
    assign o_busy    = r_busy;

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              rd_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wreg,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREGS-1:0]  busy
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_wreg;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [NREGS-1:0]  w_busy;
    logic              w_busy1;
    logic              w_busy2;
    logic              w_a_elig;
    logic              w_b_elig;
    logic              w_a_grant;
    logic              w_b_grant;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_set_en  (issue_valid),
        .i_set_reg (issue_reg),
        .i_clr_en  (w_b_grant),
        .i_clr_reg (b_reg),
        .i_rd_reg1 (rd_reg1),
        .i_rd_reg2 (rd_reg2),
        .o_busy1_c (w_busy1),
        .o_busy2_c (w_busy2),
        .o_busy    (w_busy)
    );

    // ALU writes wait behind a pending load to the same register; loads never wait.
    assign w_a_elig = a_valid && (!w_busy[a_reg] || (a_reg == ADDR_W'(REG_ZERO)));
    assign w_b_elig = b_valid;

    // Round-robin grant between eligible sources; state follows the winner.
    always_comb begin
        w_a_grant   = 1'b0;
        w_b_grant   = 1'b0;
        w_state_nxt = r_state;
        if (w_a_elig && w_b_elig) begin
            if (r_state == LAST_A) begin
                w_b_grant = 1'b1;
            end else begin
                w_a_grant = 1'b1;
            end
        end else if (w_a_elig) begin
            w_a_grant = 1'b1;
        end else if (w_b_elig) begin
            w_b_grant = 1'b1;
        end
        if (w_a_grant) begin
            w_state_nxt = LAST_A;
        end else if (w_b_grant) begin
            w_state_nxt = LAST_B;
        end
    end

    // Arbiter state register; LAST_B out of reset so A wins the first conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LAST_B;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered write port; writes to register 0 are swallowed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_we    <= 1'b0;
            r_rf_wreg  <= '0;
            r_rf_wdata <= '0;
        end else if (w_a_grant) begin
            r_rf_we    <= (a_reg != ADDR_W'(REG_ZERO));
            r_rf_wreg  <= a_reg;
            r_rf_wdata <= a_data;
        end else if (w_b_grant) begin
            r_rf_we    <= (b_reg != ADDR_W'(REG_ZERO));
            r_rf_wreg  <= b_reg;
            r_rf_wdata <= b_data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign a_ready  = w_a_grant;
    assign b_ready  = w_b_grant;
    assign rd_stall = w_busy1 | w_busy2;
    assign rf_we    = r_rf_we;
    assign rf_wreg  = r_rf_wreg;
    assign rf_wdata = r_rf_wdata;
    assign busy     = w_busy;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a negedge-commit register file model.
module tb_regfile_wb_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 32;

    logic              clk;
    logic              reset_n;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic [ADDR_W-1:0] rd_reg1;
    logic [ADDR_W-1:0] rd_reg2;
    logic              rd_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wreg;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREGS-1:0]  busy;

    logic [DATA_W-1:0] rf_mem [NREGS];

    int n_checks;
    int n_errors;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .rd_stall    (rd_stall),
        .rf_we       (rf_we),
        .rf_wreg     (rf_wreg),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file commits on the falling edge.
    always @(negedge clk) begin
        if (rf_we) rf_mem[rf_wreg] <= rf_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        a_valid     = 1'b0;
        a_reg       = '0;
        a_data      = '0;
        b_valid     = 1'b0;
        b_reg       = '0;
        b_data      = '0;
        issue_valid = 1'b0;
        issue_reg   = '0;
        rd_reg1     = '0;
        rd_reg2     = '0;
        for (int i = 0; i < int'(NREGS); i++) rf_mem[i] = '0;
        #2;
        chk("rst_we",    64'(rf_we),    64'd0);
        chk("rst_wreg",  64'(rf_wreg),  64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_busy",  64'(busy),     64'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        #1;

        // Single A write.
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'd500;
        #1;
        chk("a1_ready", 64'(a_ready), 64'd1);
        chk("a1_bready", 64'(b_ready), 64'd0);
        cyc();
        a_valid = 1'b0;
        chk("a1_we",    64'(rf_we),    64'd1);
        chk("a1_wreg",  64'(rf_wreg),  64'd5);
        chk("a1_wdata", 64'(rf_wdata), 64'd500);
        @(negedge clk); #1;
        chk("a1_rf5", 64'(rf_mem[5]), 64'd500);

        // Round robin from reset state: A, then B, then A again.
        do_reset();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
        #1;
        chk("rr1_aready", 64'(a_ready), 64'd1);
        chk("rr1_both",   64'(a_ready & b_ready), 64'd0);
        cyc();
        a_data = 32'h33;
        chk("rr1_wreg",  64'(rf_wreg),  64'd3);
        chk("rr1_wdata", 64'(rf_wdata), 64'h11);
        #1;
        chk("rr2_bready", 64'(b_ready), 64'd1);
        chk("rr2_both",   64'(a_ready & b_ready), 64'd0);
        cyc();
        b_valid = 1'b0;
        chk("rr2_wreg",  64'(rf_wreg),  64'd4);
        chk("rr2_wdata", 64'(rf_wdata), 64'h22);
        #1;
        chk("rr3_aready", 64'(a_ready), 64'd1);
        cyc();
        a_valid = 1'b0;
        chk("rr3_wreg",  64'(rf_wreg),  64'd3);
        chk("rr3_wdata", 64'(rf_wdata), 64'h33);
        cyc();
        chk("rr_idle_we", 64'(rf_we), 64'd0);
        chk("rr_hold_wreg", 64'(rf_wreg), 64'd3);

        // Load hazard on r7: A must wait for the load.
        issue_valid = 1'b1; issue_reg = 5'd7;
        cyc();
        issue_valid = 1'b0;
        chk("hz_busy7", 64'(busy[7]), 64'd1);
        rd_reg1 = 5'd7;
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hz_stall", 64'(rd_stall), 64'd1);
            chk("hz_aready", 64'(a_ready), 64'd0);
            cyc();
            chk("hz_we_idle", 64'(rf_we), 64'd0);
        end
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'hBB;
        #1;
        chk("hz_bready", 64'(b_ready), 64'd1);
        chk("hz_aready_b", 64'(a_ready), 64'd0);
        cyc();
        b_valid = 1'b0;
        chk("hz_b_we",    64'(rf_we),    64'd1);
        chk("hz_b_wreg",  64'(rf_wreg),  64'd7);
        chk("hz_b_wdata", 64'(rf_wdata), 64'hBB);
        chk("hz_clr7",    64'(busy[7]),  64'd0);
        chk("hz_nostall", 64'(rd_stall), 64'd0);
        #1;
        chk("hz_aready_go", 64'(a_ready), 64'd1);
        cyc();
        a_valid = 1'b0;
        chk("hz_a_wdata", 64'(rf_wdata), 64'hAA);
        @(negedge clk); #1;
        chk("hz_rf7", 64'(rf_mem[7]), 64'hAA);

        // Register 0 writes and issues are discarded.
        rd_reg1 = 5'd0; rd_reg2 = 5'd0;
        a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF;
        issue_valid = 1'b1; issue_reg = 5'd0;
        cyc();
        #1;
        chk("r0_aready", 64'(a_ready), 64'd1);
        cyc();
        a_valid = 1'b0; issue_valid = 1'b0;
        chk("r0_we",    64'(rf_we),    64'd0);
        chk("r0_busy0", 64'(busy[0]),  64'd0);
        chk("r0_stall", 64'(rd_stall), 64'd0);

        // Set wins over clear on the same register.
        issue_valid = 1'b1; issue_reg = 5'd9;
        cyc();
        issue_valid = 1'b0;
        rd_reg2 = 5'd9;
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h99;
        issue_valid = 1'b1; issue_reg = 5'd9;
        #1;
        chk("sc_bready", 64'(b_ready), 64'd1);
        cyc();
        b_valid = 1'b0; issue_valid = 1'b0;
        chk("sc_we",    64'(rf_we),    64'd1);
        chk("sc_busy9", 64'(busy[9]),  64'd1);
        chk("sc_stall", 64'(rd_stall), 64'd1);
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h9A;
        cyc();
        b_reg = 5'd12; b_data = 32'hC0;
        chk("sc_clr9", 64'(busy), 64'd0);
        cyc();
        b_valid = 1'b0;
        chk("nb_busy",  64'(busy),    64'd0);
        chk("nb_wreg",  64'(rf_wreg), 64'd12);

        // Reset while a write is on the port.
        issue_valid = 1'b1; issue_reg = 5'd10;
        a_valid = 1'b1; a_reg = 5'd2; a_data = 32'h5;
        cyc();
        issue_valid = 1'b0; a_valid = 1'b0;
        chk("mr_we_pre",   64'(rf_we),    64'd1);
        chk("mr_busy_pre", 64'(busy[10]), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mr_we",   64'(rf_we),   64'd0);
        chk("mr_busy", 64'(busy),    64'd0);
        chk("mr_wreg", 64'(rf_wreg), 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
